fpu_resp_router: RTL

- Return path of the shared-FPU interconnect; counterpart of the request-side allocator.
- Records which core issued each operation on each APU, in a per-APU in-order tag FIFO.
- Routes each APU result back to the originating core with a registered, 1-cycle-latency output.
- Arbitrates when several APUs return to the same core in the same cycle.

---
 rtl/fpu_resp_router.sv | 249 ++++++++++++++++++++++++
 1 files changed

// File: rtl/fpu_resp_router.sv
// ---------------------------------------------------------------------------
// fpu_resp_router
//   Return path of the shared-FPU interconnect. Each issued operation leaves
//   the issuing core index in an in-order tag FIFO of the APU it went to.
//   When that APU returns a result, the head tag names the core to which the
//   result is routed. The core-side response is registered, so it appears
//   one cycle after the APU result is accepted.
//
//   Optional feature (macro FPU_RESP_ROUTER_ERR_CNT_EN):
//     adds err_cnt_o[15:0], a saturating count of cycles with an error event.
//
// Ports
//   clk, rst_n       clock, synchronous active-low reset
//   core_req_i       per-core request valid
//   core_gnt_i       per-core grant; an issue is req & gnt
//   routing_addr_i   APU selected for each core
//   apu_full_o       per-APU tag FIFO full (combinational from occupancy)
//   apu_rvalid_i     per-APU result valid
//   apu_rready_o     per-APU result accepted this cycle
//   apu_rdata_i      per-APU result data
//   apu_rflags_i     per-APU result flags
//   core_rvalid_o    per-core registered response pulse
//   core_rdata_o     per-core registered response data
//   core_rflags_o    per-core registered response flags
//   err_cnt_o        saturating error-cycle count (macro only)
//   err_o            sticky protocol error
// ---------------------------------------------------------------------------
module fpu_resp_router #(
  parameter int NB_CORES    = 4,
  parameter int NB_APUS     = 2,
  parameter int DATA_WIDTH  = 32,
  parameter int FLAGS_WIDTH = 5,
  parameter int DEPTH       = 4,
  localparam int AW = (NB_APUS > 1) ? $clog2(NB_APUS) : 1,
  localparam int CW = (NB_CORES > 1) ? $clog2(NB_CORES) : 1
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic [NB_CORES-1:0]                     core_req_i,
  input  logic [NB_CORES-1:0]                     core_gnt_i,
  input  logic [NB_CORES-1:0][AW-1:0]             routing_addr_i,
  output logic [NB_APUS-1:0]                      apu_full_o,
  input  logic [NB_APUS-1:0]                      apu_rvalid_i,
  output logic [NB_APUS-1:0]                      apu_rready_o,
  input  logic [NB_APUS-1:0][DATA_WIDTH-1:0]      apu_rdata_i,
  input  logic [NB_APUS-1:0][FLAGS_WIDTH-1:0]     apu_rflags_i,
  output logic [NB_CORES-1:0]                     core_rvalid_o,
  output logic [NB_CORES-1:0][DATA_WIDTH-1:0]     core_rdata_o,
  output logic [NB_CORES-1:0][FLAGS_WIDTH-1:0]    core_rflags_o,
`ifdef FPU_RESP_ROUTER_ERR_CNT_EN
  output logic [15:0]                             err_cnt_o,
`else
`endif
  output logic                                    err_o
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0]   FULL_CNT = (PW + 1)'(DEPTH);
  localparam logic [PW:0]   CNT_ONE  = (PW + 1)'(1);
  localparam logic [PW:0]   CNT_ZERO = (PW + 1)'(0);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  // Tag FIFO state, one FIFO per APU
  logic [CW-1:0] tag_mem_r [NB_APUS][DEPTH];
  logic [PW-1:0] wr_ptr_r  [NB_APUS];
  logic [PW-1:0] rd_ptr_r  [NB_APUS];
  logic [PW:0]   cnt_r     [NB_APUS];

  // Combinational decisions for the current cycle
  logic [NB_CORES-1:0] issue_s;
  logic [NB_APUS-1:0]  push_s;
  logic [CW-1:0]       push_tag_s [NB_APUS];
  logic [NB_APUS-1:0]  push_ok_s;
  logic [NB_APUS-1:0]  full_s;
  logic [CW-1:0]       head_s     [NB_APUS];
  logic [NB_APUS-1:0]  win_s;
  logic [NB_APUS-1:0]  rready_s;
  logic [NB_CORES-1:0] claimed_s;
  logic [AW-1:0]       core_src_s [NB_CORES];
  logic                err_push_s;
  logic                err_empty_s;
  logic                err_full_s;
  logic                err_any_s;

  // Registered outputs
  logic [NB_CORES-1:0]                  core_rvalid_r;
  logic [NB_CORES-1:0][DATA_WIDTH-1:0]  core_rdata_r;
  logic [NB_CORES-1:0][FLAGS_WIDTH-1:0] core_rflags_r;
  logic                                 err_r;

  assign issue_s = core_req_i & core_gnt_i;

  // Push selection: lowest core index wins an APU, duplicates are flagged
  always_comb begin
    push_s     = '0;
    err_push_s = 1'b0;
    for (int k = 0; k < NB_APUS; k++) begin
      push_tag_s[k] = '0;
    end
    for (int j = 0; j < NB_CORES; j++) begin
      if (issue_s[j]) begin
        if (int'(routing_addr_i[j]) >= NB_APUS) begin
          err_push_s = 1'b1;
        end else if (push_s[routing_addr_i[j]]) begin
          err_push_s = 1'b1;
        end else begin
          push_s[routing_addr_i[j]]     = 1'b1;
          push_tag_s[routing_addr_i[j]] = CW'(j);
        end
      end else begin
        err_push_s = err_push_s;
      end
    end
  end

  // Head-of-FIFO tag and full flag per APU
  always_comb begin
    for (int k = 0; k < NB_APUS; k++) begin
      head_s[k] = tag_mem_r[k][rd_ptr_r[k]];
      full_s[k] = (cnt_r[k] == FULL_CNT);
    end
  end

  // Pop arbitration: lowest APU index claims a core first; an empty FIFO
  // still accepts the result so a stray APU cannot stall, but it is an error
  always_comb begin
    win_s       = '0;
    rready_s    = '0;
    claimed_s   = '0;
    err_empty_s = 1'b0;
    for (int j = 0; j < NB_CORES; j++) begin
      core_src_s[j] = '0;
    end
    for (int k = 0; k < NB_APUS; k++) begin
      if (!apu_rvalid_i[k]) begin
        rready_s[k] = 1'b0;
      end else if (cnt_r[k] == CNT_ZERO) begin
        rready_s[k] = 1'b1;
        err_empty_s = 1'b1;
      end else if (claimed_s[head_s[k]]) begin
        rready_s[k] = 1'b0;
      end else begin
        win_s[k]              = 1'b1;
        rready_s[k]           = 1'b1;
        claimed_s[head_s[k]]  = 1'b1;
        core_src_s[head_s[k]] = AW'(k);
      end
    end
  end

  // A full FIFO only takes a push when it pops in the same cycle
  always_comb begin
    err_full_s = 1'b0;
    for (int k = 0; k < NB_APUS; k++) begin
      push_ok_s[k] = push_s[k] & (~full_s[k] | win_s[k]);
      if (push_s[k] && full_s[k] && !win_s[k]) begin
        err_full_s = 1'b1;
      end else begin
        err_full_s = err_full_s;
      end
    end
  end

  assign err_any_s = err_push_s | err_empty_s | err_full_s;

  // Tag storage write (contents are don't-care while the FIFO is empty)
  always_ff @(posedge clk) begin
    for (int k = 0; k < NB_APUS; k++) begin
      if (push_ok_s[k]) begin
        tag_mem_r[k][wr_ptr_r[k]] <= push_tag_s[k];
      end
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < NB_APUS; k++) begin
        wr_ptr_r[k] <= '0;
        rd_ptr_r[k] <= '0;
        cnt_r[k]    <= '0;
      end
    end else begin
      for (int k = 0; k < NB_APUS; k++) begin
        if (push_ok_s[k]) begin
          wr_ptr_r[k] <= wr_ptr_r[k] + PTR_ONE;
        end
        if (win_s[k]) begin
          rd_ptr_r[k] <= rd_ptr_r[k] + PTR_ONE;
        end
        case ({push_ok_s[k], win_s[k]})
          2'b10:   cnt_r[k] <= cnt_r[k] + CNT_ONE;
          2'b01:   cnt_r[k] <= cnt_r[k] - CNT_ONE;
          default: cnt_r[k] <= cnt_r[k];
        endcase
      end
    end
  end

  // Core response registers; data only reloads for a core that got a result
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      core_rvalid_r <= '0;
      core_rdata_r  <= '0;
      core_rflags_r <= '0;
    end else begin
      core_rvalid_r <= claimed_s;
      for (int j = 0; j < NB_CORES; j++) begin
        if (claimed_s[j]) begin
          core_rdata_r[j]  <= apu_rdata_i[core_src_s[j]];
          core_rflags_r[j] <= apu_rflags_i[core_src_s[j]];
        end
      end
    end
  end

  // Sticky error flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_r <= 1'b0;
    end else if (err_any_s) begin
      err_r <= 1'b1;
    end
  end

`ifdef FPU_RESP_ROUTER_ERR_CNT_EN
  logic [15:0] err_cnt_r;

  // Saturating count of cycles with at least one error event
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_cnt_r <= 16'h0000;
    end else if (err_any_s && (err_cnt_r != 16'hFFFF)) begin
      err_cnt_r <= err_cnt_r + 16'h0001;
    end
  end

  assign err_cnt_o = err_cnt_r;
`else
`endif

  assign apu_full_o    = full_s;
  assign apu_rready_o  = rready_s;
  assign core_rvalid_o = core_rvalid_r;
  assign core_rdata_o  = core_rdata_r;
  assign core_rflags_o = core_rflags_r;
  assign err_o         = err_r;

endmodule
